spi_cmd_decoder: RTL
====================

# spi_cmd_decoder

Consumes the byte stream from `spi_slave` (`byte_out`/`byte_ready`) and parses it into register-write packets for the centrifuge configuration bank. Holds the register bank and presents it flattened to the video pipeline. Frames are delimited by the SPI slave-select, and malformed packets are counted and discarded.

## Interface
- `NUM_REGS`, default 8: number of configuration registers; valid addresses are 0..NUM_REGS-1 (NUM_REGS ≤ 128).
- `DATA_BYTES`, default 2: payload bytes per register; register width W = 8*DATA_BYTES.

- `clk`  in  1  system clock, same domain as `spi_slave.clk`.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `byte_in`  in  8  received byte, connected to `spi_slave.byte_out`.
- `byte_valid`  in  1  one-cycle strobe, connected to `byte_ready`.
- `frame_active`  in  1  high while SS is asserted; already synchronised to `clk`.
- `wr_en`  out  1  one-cycle pulse per committed write.
- `wr_addr`  out  7  address of the last committed write.
- `wr_data`  out  W  data of the last committed write.
- `regs_flat`  out  NUM_REGS*W  register bank; reg i is at bits [i*W +: W].
- `err_count`  out  8  saturating count of rejected packets.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Packet format:
  - Command byte C: bit7 = 1 means write, bits[6:0] = address.
  - Then DATA_BYTES data bytes, MSB first.
  - Then, if configured, one checksum byte.
- States: IDLE, DATA, CHECK (macro only), DISCARD.
- IDLE + byte:
  - C[7]=1 and addr < NUM_REGS: latch addr, clear byte counter, go to DATA.
  - C[7]=1 and addr ≥ NUM_REGS: err+1, go to DISCARD.
  - C[7]=0: no-op; stay in IDLE.
- DATA + byte: shift the byte into a W-bit accumulator (shift left 8) and increment the counter.
  - On the DATA_BYTES-th byte: commit, or go to CHECK if configured.
- Commit:
  - `regs[addr]` <= data, `wr_addr` <= addr, `wr_data` <= data, and `wr_en` = 1 for exactly one cycle.
  - State returns to IDLE, so back-to-back packets are allowed in one frame.
- DISCARD: ignore bytes until `frame_active` = 0, then go to IDLE.
- Abort: in any cycle with `frame_active` = 0, `byte_valid` = 0 and state ∈ {DATA, CHECK}:
  - err+1, no write, go to IDLE.
  - Partial accumulator contents are never written.
- `byte_valid` is processed in every cycle regardless of `frame_active`. The abort check applies only to cycles without `byte_valid`, so a final byte coincident with SS release still completes its packet.
- `err_count` saturates at 255.
- Reset values: all outputs 0, `regs_flat` all 0, state IDLE, accumulator and counter cleared.
- Reset mid-packet: the packet is lost, no write occurs, and `err_count` is not incremented.

## Timing
- Byte sampled at edge E (last byte of packet) → `wr_en`, `wr_addr`, `wr_data` and `regs_flat` are all updated at E and visible in the following cycle. Latency is 1 cycle.
- `wr_en` is registered and never high for two consecutive cycles. Bytes arrive at ≥ 16 clk spacing, but a commit followed by a byte on the next cycle is still legal.
- `err_count` updates at the same edge that detects the error.
- `busy` is registered from the next-state value and rises in the cycle after the command byte.
- No back-pressure: every `byte_valid` is consumed in its cycle.

## Configuration
- `SPI_CMD_CHECKSUM_EN` defined:
  - After the data bytes the block expects checksum K = C ^ D0 ^ … ^ D(n-1).
  - State CHECK is present.
  - K match: commit.
  - K mismatch: err+1, no write, go to IDLE.
- `SPI_CMD_CHECKSUM_EN` undefined: the CHECK state and XOR logic are absent, and the block commits on the last data byte.

## Test plan
- Frame 0x83,0x12,0x34 (no macro) → one `wr_en` pulse, `wr_addr` = 3, `wr_data` = 0x1234, `regs_flat`[63:48] = 0x1234, `err_count` = 0.
- One frame containing 0x80,0xAA,0x55,0x81,0x01,0x02 → two `wr_en` pulses; reg0 = 0xAA55, reg1 = 0x0102.
- 0x85,0x12, then `frame_active` falls → no write, `err_count` = 1, `busy` = 0 one cycle after the fall.
- 0x8A (addr 10 ≥ 8),0x11,0x22,0x83 in one frame → `err_count` = 1, no writes, 0x83 ignored (DISCARD); the next frame writes normally.
- Macro on: 0x82,0x12,0x34,0xA4 → reg2 = 0x1234. Then 0x82,0x12,0x34,0x00 → no write, `err_count` +1.
- Assert `rst_n` = 0 after 0x84,0x77 → all outputs and regs read 0 and state is IDLE. After release, 0x84,0x00,0x01 → reg4 = 0x0001.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI byte-stream command parser and register bank; optional checksum byte via SPI_CMD_CHECKSUM_EN
module spi_cmd_decoder #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_BYTES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       byte_in,
  input  logic                             byte_valid,
  input  logic                             frame_active,
  output logic                             wr_en,
  output logic [6:0]                       wr_addr,
  output logic [8*DATA_BYTES-1:0]          wr_data,
  output logic [NUM_REGS*8*DATA_BYTES-1:0] regs_flat,
  output logic [7:0]                       err_count,
  output logic                             busy
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
`ifdef SPI_CMD_CHECKSUM_EN
  localparam logic [1:0] CHECK   = 2'd2;
`endif
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [6:0]          addr_q, addr_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        acc_shift;
  logic [W-1:0]        commit_data;
  logic                commit;
  logic                err_inc;
  logic                addr_ok;
  logic                last_byte;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                wr_en_q;
  logic [6:0]          wr_addr_q;
  logic [W-1:0]        wr_data_q;
  logic [NUM_REGS*W-1:0] regs_q;
  logic [7:0]          err_q;
  logic                busy_q;

  assign acc_shift = W'({acc_q, byte_in});
  assign addr_ok   = ({1'b0, byte_in[6:0]} < 8'(NUM_REGS));
  assign last_byte = (cnt_q == CW'(DATA_BYTES - 1));

  // Packet parser: next state, accumulator, and commit/error decisions
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    commit_data = acc_shift;
    err_inc     = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (byte_valid && byte_in[7]) begin
          if (addr_ok) begin
            addr_d  = byte_in[6:0];
            acc_d   = '0;
            cnt_d   = '0;
            state_d = DATA;
`ifdef SPI_CMD_CHECKSUM_EN
            csum_d  = byte_in;
`endif
          end else begin
            err_inc = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          acc_d = acc_shift;
          cnt_d = cnt_q + 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
          if (last_byte) state_d = CHECK;
`else
          if (last_byte) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
`endif
        end else if (!frame_active) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef SPI_CMD_CHECKSUM_EN
      CHECK: begin
        commit_data = acc_q;
        if (byte_valid) begin
          if (byte_in == csum_q) commit = 1'b1;
          else err_inc = 1'b1;
          state_d = IDLE;
        end else if (!frame_active) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      DISCARD: begin
        if (!frame_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Commit into the register bank and write-report outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q    <= '0;
    end else begin
      wr_en_q <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= commit_data;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == i[6:0]) regs_q[i*W +: W] <= commit_data;
        end
      end
    end
  end

  // Saturating error counter and busy flag registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      busy_q <= (state_d != IDLE);
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign regs_flat = regs_q;
  assign err_count = err_q;
  assign busy      = busy_q;

endmodule
